// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
//
// Buffered 8N1 UART transmitter. Bytes offered on a valid/ready handshake are
// queued in a small power-of-two FIFO. A four-state serialiser drains the FIFO
// and sends one frame per byte: a start bit (0), eight data bits LSB first,
// then a stop bit (1). Every symbol lasts ClockFreq/BaudRate clock cycles,
// truncated to an integer. When the FIFO still holds a byte at the last cycle
// of a stop bit, the next frame starts on the following edge, so back-to-back
// frames leave no idle gap on the line.
//
// Parameters
//   ClockFreq   CLK frequency in Hz
//   BaudRate    serial bit rate in bits/s
//   Depth       FIFO entries (power of two, 2..16)
//
// Ports
//   CLK          single clock; all state updates on its rising edge
//   reset        synchronous, active-high reset
//   DataIn       byte offered by the datapath
//   DataInValid  DataIn is valid this cycle
//   DataInReady  a byte is accepted this cycle (FIFO not full, not in reset)
//   SOut         serial line, idle high, driven straight from a flop
//   TxBusy       a frame is in progress or the FIFO is non-empty
// ---------------------------------------------------------------------------
module uart_tx_buffered #(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200,
  parameter int Depth     = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic       SOut,
  output logic       TxBusy
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int CntW           = $clog2(SymbolEdgeTime + 1);
  localparam int PtrW           = $clog2(Depth);
  localparam int CountW         = $clog2(Depth + 1);

  // The symbol counter runs 0..SymbolEdgeTime-1; the last value marks the
  // final cycle of the current symbol.
  localparam logic [CntW-1:0]   SymLast   = CntW'(SymbolEdgeTime - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(Depth);
  localparam logic [2:0]        BitLast   = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [7:0]        mem [Depth];
  logic [PtrW-1:0]   wr_ptr_reg;
  logic [PtrW-1:0]   rd_ptr_reg;
  logic [CountW-1:0] count_reg;

  state_t            state_reg;
  state_t            state_next;
  logic [CntW-1:0]   sym_cnt_reg;
  logic [CntW-1:0]   sym_cnt_next;
  logic [2:0]        bit_cnt_reg;
  logic [2:0]        bit_cnt_next;
  logic [7:0]        shift_reg;
  logic              sout_reg;
  logic              sout_next;

  // Control strobes produced by the FSM for the datapath.
  logic              pop;
  logic              shift_en;
  logic              sym_done;
  logic              push;

  // -------------------------------------------------------------------------
  // Handshake and status
  // -------------------------------------------------------------------------
  // Ready depends only on the registered count and on reset; a full FIFO never
  // accepts, even if a pop happens on the same edge.
  assign DataInReady = (count_reg < CountFull) && !reset;
  assign push        = DataInValid && DataInReady;

  assign TxBusy      = (state_reg != IDLE) || (count_reg != '0);
  assign SOut        = sout_reg;

  // -------------------------------------------------------------------------
  // FIFO storage: write port only, no reset so it maps onto memory.
  // A full FIFO never accepts, and an empty FIFO never pops, so a write can
  // never land on the entry being read in the same cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= DataIn;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy. Pointers wrap naturally because Depth is a
  // power of two. Reset wins over any simultaneous push or pop.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + CountW'(1);
        2'b01:   count_reg <= count_reg - CountW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Shift register. Loading it on a pop is the registered read of the FIFO
  // memory. Each time a data bit is driven onto the line, bit 0 is emitted
  // and the register moves one place towards the LSB.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (pop) begin
      shift_reg <= mem[rd_ptr_reg];
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register, including the line flop so SOut has no path from any
  // input.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg   <= IDLE;
      sym_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      sout_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      sym_cnt_reg <= sym_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      sout_reg    <= sout_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and control
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    sym_cnt_next = sym_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    sout_next    = sout_reg;
    pop          = 1'b0;
    shift_en     = 1'b0;
    sym_done     = (sym_cnt_reg == SymLast);

    unique case (state_reg)
      IDLE: begin
        sout_next = 1'b1;
        if (count_reg != '0) begin
          pop          = 1'b1;
          state_next   = START;
          sout_next    = 1'b0;
          sym_cnt_next = '0;
          bit_cnt_next = '0;
        end
      end

      START: begin
        if (sym_done) begin
          // The first data bit goes out as the start bit ends.
          state_next   = DATA;
          sym_cnt_next = '0;
          sout_next    = shift_reg[0];
          shift_en     = 1'b1;
        end else begin
          sym_cnt_next = sym_cnt_reg + CntW'(1);
        end
      end

      DATA: begin
        if (sym_done) begin
          sym_cnt_next = '0;
          if (bit_cnt_reg == BitLast) begin
            state_next = STOP;
            sout_next  = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            sout_next    = shift_reg[0];
            shift_en     = 1'b1;
          end
        end else begin
          sym_cnt_next = sym_cnt_reg + CntW'(1);
        end
      end

      STOP: begin
        if (sym_done) begin
          sym_cnt_next = '0;
          if (count_reg != '0) begin
            // Chain straight into the next frame with no idle cycle.
            pop          = 1'b1;
            state_next   = START;
            sout_next    = 1'b0;
            bit_cnt_next = '0;
          end else begin
            state_next = IDLE;
            sout_next  = 1'b1;
          end
        end else begin
          sym_cnt_next = sym_cnt_reg + CntW'(1);
        end
      end

      default: begin
        state_next   = IDLE;
        sout_next    = 1'b1;
        sym_cnt_next = '0;
        bit_cnt_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
//
// Directed bench for uart_tx_buffered at ClockFreq=100, BaudRate=10, Depth=4,
// which gives 10 cycles per symbol. A second instance at ClockFreq=105 checks
// that the symbol time is truncated to the same 10 cycles. Expected frames are
// written out by hand in the vector table as {stop, data[7:0], start}, so
// bit s of a frame is the line level during symbol s.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

  logic       CLK;
  logic       reset;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;
  logic       SOut;
  logic       TxBusy;

  logic [7:0] din_t;
  logic       valid_t;
  logic       ready_t;
  logic       sout_t;
  logic       busy_t;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] din;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [17];

  uart_tx_buffered #(
    .ClockFreq(100),
    .BaudRate (10),
    .Depth    (4)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .DataIn     (DataIn),
    .DataInValid(DataInValid),
    .DataInReady(DataInReady),
    .SOut       (SOut),
    .TxBusy     (TxBusy)
  );

  uart_tx_buffered #(
    .ClockFreq(105),
    .BaudRate (10),
    .Depth    (4)
  ) dut_t (
    .CLK        (CLK),
    .reset      (reset),
    .DataIn     (din_t),
    .DataInValid(valid_t),
    .DataInReady(ready_t),
    .SOut       (sout_t),
    .TxBusy     (busy_t)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Checks the next 100 cycles: each symbol must hold its level for all ten
  // of its cycles.
  task automatic check_frame(input string name, input logic [9:0] exp, input bit sel);
    logic bad;
    logic got;
    logic cur;
    for (int s = 0; s < 10; s++) begin
      bad = 1'b0;
      got = exp[s];
      for (int c = 0; c < 10; c++) begin
        @(negedge CLK);
        cur = sel ? sout_t : SOut;
        if (cur !== exp[s]) begin
          bad = 1'b1;
          got = cur;
        end
      end
      n_vec++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s symbol %0d: SOut got %b, required %b for all 10 cycles",
                 name, s, got, exp[s]);
      end
    end
  endtask

  // One byte into an idle block; called on a negedge.
  task automatic single_send(input int idx, input bit sel);
    string nm;
    nm = $sformatf("%s byte %02h", sel ? "trunc" : "single", vecs[idx].din);
    chk({nm, " ready before push"}, sel ? ready_t : DataInReady, 1);
    if (sel) begin
      din_t   = vecs[idx].din;
      valid_t = 1'b1;
    end else begin
      DataIn      = vecs[idx].din;
      DataInValid = 1'b1;
    end
    @(negedge CLK);  // edge k has accepted the byte
    valid_t     = 1'b0;
    DataInValid = 1'b0;
    chk({nm, " busy after accept"}, sel ? busy_t : TxBusy, 1);
    chk({nm, " line still high at k"}, sel ? sout_t : SOut, 1);
    check_frame(nm, vecs[idx].exp, sel);
    @(negedge CLK);  // edge k+101
    chk({nm, " busy clear at k+101"}, sel ? busy_t : TxBusy, 0);
    $display("single: %s sent, frame checked", nm);
  endtask

  // Streams n bytes from the table with DataInValid held high; called on a
  // negedge, which precedes edge 0. With noise set, DataIn carries random
  // garbage whenever the block is not ready.
  task automatic push_stream(input int first, input int n, input bit noise,
                             output int last_edge, output int n_early);
    int  nb;
    int  cyc;
    logic rdy;
    nb        = 0;
    cyc       = 0;
    last_edge = -1;
    n_early   = 0;
    DataInValid = 1'b1;
    while (nb < n && cyc < 400) begin
      rdy = DataInReady;
      if (rdy || !noise) DataIn = vecs[first + nb].din;
      else               DataIn = 8'($urandom);
      @(posedge CLK);
      if (rdy) begin
        last_edge = cyc;
        if (cyc <= 100) n_early++;
        $display("push: byte %02h accepted at edge k+%0d", vecs[first + nb].din, cyc);
        nb++;
      end
      @(negedge CLK);
      cyc++;
    end
    DataInValid = 1'b0;
    DataIn      = 8'h00;
  endtask

  task automatic stream_test(input string nm, input int first, input bit noise);
    int last_edge;
    int n_early;
    fork
      begin
        push_stream(first, 6, noise, last_edge, n_early);
      end
      begin
        @(negedge CLK);
        chk({nm, " line high at k"}, SOut, 1);
        for (int f = 0; f < 6; f++) begin
          check_frame($sformatf("%s frame %0d", nm, f), vecs[first + f].exp, 1'b0);
        end
        @(negedge CLK);
        chk({nm, " busy clear after 600 cycles"}, TxBusy, 0);
        chk({nm, " line idle after 600 cycles"}, SOut, 1);
      end
    join
    chk({nm, " accepted by end of frame 1"}, n_early, 5);
    chk({nm, " edge of 6th accept"}, last_edge, 102);
    $display("stream: %s done", nm);
  endtask

  initial begin
    logic [7:0] abort_bytes [4];
    logic bad_line;
    logic bad_busy;

    vecs[0]  = '{8'hA5, 10'b1101001010};
    vecs[1]  = '{8'h00, 10'b1000000000};
    vecs[2]  = '{8'hFF, 10'b1111111110};
    vecs[3]  = '{8'h3C, 10'b1001111000};
    vecs[4]  = '{8'h01, 10'b1000000010};
    vecs[5]  = '{8'h02, 10'b1000000100};
    vecs[6]  = '{8'h03, 10'b1000000110};
    vecs[7]  = '{8'h04, 10'b1000001000};
    vecs[8]  = '{8'h05, 10'b1000001010};
    vecs[9]  = '{8'h06, 10'b1000001100};
    vecs[10] = '{8'h3C, 10'b1001111000};
    vecs[11] = '{8'hC3, 10'b1110000110};
    vecs[12] = '{8'h00, 10'b1000000000};
    vecs[13] = '{8'hFF, 10'b1111111110};
    vecs[14] = '{8'h81, 10'b1100000010};
    vecs[15] = '{8'h7E, 10'b1011111100};
    vecs[16] = '{8'h55, 10'b1010101010};

    abort_bytes[0] = 8'hF0;
    abort_bytes[1] = 8'h11;
    abort_bytes[2] = 8'h22;
    abort_bytes[3] = 8'h33;

    reset       = 1'b1;
    DataIn      = 8'h00;
    DataInValid = 1'b0;
    din_t       = 8'h00;
    valid_t     = 1'b0;

    // Reset: two edges with reset high.
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk($sformatf("reset cycle %0d SOut", i), SOut, 1);
      chk($sformatf("reset cycle %0d ready", i), DataInReady, 0);
    end
    reset = 1'b0;
    @(negedge CLK);
    chk("after reset ready", DataInReady, 1);
    chk("after reset busy", TxBusy, 0);
    chk("after reset SOut", SOut, 1);
    chk("after reset trunc ready", ready_t, 1);
    $display("reset: done");

    // Single-byte frames from the table.
    for (int i = 0; i < 4; i++) begin
      single_send(i, 1'b0);
    end

    // Fill and stall streams, six frames each.
    stream_test("fill", 4, 1'b0);
    stream_test("stall", 10, 1'b1);

    // Abort: 0xF0 in flight with three bytes queued, reset during bit 3.
    DataInValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      DataIn = abort_bytes[i];
      chk($sformatf("abort push %0d ready", i), DataInReady, 1);
      @(negedge CLK);
    end
    DataInValid = 1'b0;
    repeat (41) @(negedge CLK);  // after edge k+44, inside data bit 3
    chk("abort bit3 level", SOut, 0);
    chk("abort busy before reset", TxBusy, 1);
    reset = 1'b1;
    @(negedge CLK);
    chk("abort SOut after reset edge", SOut, 1);
    chk("abort busy after reset edge", TxBusy, 0);
    chk("abort ready during reset", DataInReady, 0);
    reset = 1'b0;
    bad_line = 1'b0;
    bad_busy = 1'b0;
    repeat (150) begin
      @(negedge CLK);
      if (SOut !== 1'b1)   bad_line = 1'b1;
      if (TxBusy !== 1'b0) bad_busy = 1'b1;
    end
    chk("abort no frame after release", bad_line, 0);
    chk("abort busy stays clear", bad_busy, 0);
    chk("abort ready after release", DataInReady, 1);
    $display("abort: done");

    // Truncated symbol time on the second instance.
    single_send(16, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
